// File: rtl/weight_memory_write_control.sv
// rtl/weight_memory_write_control.sv - striped weight-stream writer into BANK_COUNT weight memory banks
// Optional feature macro: WEIGHT_WORD_COUNT_CHECK_EN (beat count vs expected_words check -> count_error)
module weight_memory_write_control #(
  parameter  int DATA_WIDTH = 64,
  parameter  int BANK_COUNT = 4,
  parameter  int BANK_DEPTH = 512,
  localparam int AW         = $clog2(BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [15:0]           expected_words,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [BANK_COUNT-1:0] wm_wen,
  output logic [AW-1:0]         wm_addr,
  output logic [DATA_WIDTH-1:0] wm_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_error,
  output logic                  count_error
);

  localparam int BW = $clog2(BANK_COUNT);
  localparam logic [BW-1:0] PTR_MAX = BW'(BANK_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                state_q, state_d;
  // Row address carries one extra bit: once set it marks "past the last row"
  // and freezes, so the address never wraps back to 0.
  logic [AW:0]           row_q, row_d;
  logic [BW-1:0]         ptr_q, ptr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           cnt_inc;
  logic                  ovf_q, ovf_d;
  logic [BANK_COUNT-1:0] wen_q, wen_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

`ifdef WEIGHT_WORD_COUNT_CHECK_EN
  logic [15:0]           exp_q, exp_d;
  logic                  cerr_q, cerr_d;
`else
  logic                  unused_expected_words;
  assign unused_expected_words = ^expected_words;
`endif

  // Next-state, striping and error-flag logic for one load.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wen_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`ifdef WEIGHT_WORD_COUNT_CHECK_EN
    exp_d   = exp_q;
    cerr_d  = cerr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = {1'b0, base_addr};
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef WEIGHT_WORD_COUNT_CHECK_EN
          exp_d   = expected_words;
          cerr_d  = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          cnt_d = cnt_inc;
          // Beats past the last row are consumed but never written.
          if (row_q[AW]) begin
            ovf_d = 1'b1;
          end else begin
            wen_d[ptr_q] = 1'b1;
            addr_d       = row_q[AW-1:0];
            data_d       = s_data;
          end
          if (ptr_q == PTR_MAX) begin
            ptr_d = '0;
            if (!row_q[AW]) begin
              row_d = row_q + 1'b1;
            end
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
          if (s_last) begin
            state_d = S_DONE;
`ifdef WEIGHT_WORD_COUNT_CHECK_EN
            cerr_d  = (cnt_inc != exp_q);
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered write-port flops; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wen_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef WEIGHT_WORD_COUNT_CHECK_EN
      exp_q   <= '0;
      cerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef WEIGHT_WORD_COUNT_CHECK_EN
      exp_q   <= exp_d;
      cerr_q  <= cerr_d;
`endif
    end
  end

  assign s_ready        = (state_q == S_LOAD);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign wm_wen         = wen_q;
  assign wm_addr        = addr_q;
  assign wm_data        = data_q;
  assign overflow_error = ovf_q;
`ifdef WEIGHT_WORD_COUNT_CHECK_EN
  assign count_error    = cerr_q;
`else
  assign count_error    = 1'b0;
`endif

endmodule

// File: tb/tb_weight_memory_write_control.sv
// tb/tb_weight_memory_write_control.sv - randomized self-checking bench for weight_memory_write_control
module tb_weight_memory_write_control;

  localparam int DW    = 64;
  localparam int BC    = 4;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   expected_words = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [BC-1:0] wm_wen;
  logic [AW-1:0] wm_addr;
  logic [DW-1:0] wm_data;
  logic          busy, done, overflow_error, count_error;

  weight_memory_write_control #(.DATA_WIDTH(DW), .BANK_COUNT(BC), .BANK_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .expected_words(expected_words), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .wm_wen(wm_wen), .wm_addr(wm_addr),
    .wm_data(wm_data), .busy(busy), .done(done),
    .overflow_error(overflow_error), .count_error(count_error)
  );

  always #5 clk = ~clk;

  // One record per cycle: DUT outputs plus the bench's own view of what
  // happened on the preceding edge (acc = beat index accepted, mst = 0 idle,
  // 1 loading, 2 completion cycle).
  typedef struct {
    logic [BC-1:0] wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done, busy, rdy, ovf, cerr;
    int            acc;
    int            mst;
  } obs_t;

  obs_t          obs[$];
  logic [DW-1:0] beats[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  // Reference model: beat k lands in bank k mod BC at row base + k / BC.
  function automatic int exp_row(input int base, input int k);
    return base + k / BC;
  endfunction

  function automatic logic [BC-1:0] exp_wen(input int base, input int k);
    logic [BC-1:0] w;
    w = '0;
    if (k >= 0 && exp_row(base, k) <= DEPTH - 1) w[k % BC] = 1'b1;
    return w;
  endfunction

  function automatic logic exp_ovf(input int base, input int n);
    return exp_row(base, n - 1) > DEPTH - 1;
  endfunction

  function automatic logic exp_cerr(input int n, input int expw);
`ifdef WEIGHT_WORD_COUNT_CHECK_EN
    return n != expw;
`else
    return 1'b0;
`endif
  endfunction

  // Issue a start, stream n random beats (gap=1: valid every other cycle),
  // optionally pulse a stray start at cycle stray_at or reset when beat reset_at
  // is presented, and record every cycle until the block is idle again.
  task automatic drive_load(input int base, input int n, input int expw,
                            input int gap, input int stray_at, input int reset_at);
    int   k, prev, cyc, post, mst;
    obs_t o;
    obs.delete();
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    @(negedge clk);
    resetn = 1'b1; start = 1'b1; base_addr = AW'(base); expected_words = 16'(expw);
    @(posedge clk);
    mst = 1; k = 0; prev = -1; cyc = 0; post = 0;
    while (post < 2 && cyc < 400) begin
      @(negedge clk);
      o.wen = wm_wen; o.addr = wm_addr; o.data = wm_data; o.done = done;
      o.busy = busy; o.rdy = s_ready; o.ovf = overflow_error; o.cerr = count_error;
      o.acc = prev; o.mst = mst;
      obs.push_back(o);
      start = 1'b0; s_valid = 1'b0; s_last = 1'b0; resetn = 1'b1;
      if (mst == 1 && k < n && (gap == 0 || cyc % 2 == 0)) begin
        s_valid = 1'b1; s_data = beats[k]; s_last = (k == n - 1);
      end
      if (cyc == stray_at) begin start = 1'b1; base_addr = AW'(100); end
      if (reset_at >= 0 && k == reset_at && mst == 1) resetn = 1'b0;
      @(posedge clk);
      prev = -1;
      if (!resetn) mst = 0;
      else if (mst == 2) mst = 0;
      else if (mst == 1 && s_valid) begin
        prev = k;
        if (s_last) mst = 2;
        k++;
      end
      if (mst == 0) post++;
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0; resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (wm_wen !== '0) begin n_fail++; $display("FAIL rst_wen got %b want 0", wm_wen); end
    n_cmp++; if (wm_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", wm_addr); end
    n_cmp++; if (wm_data !== '0) begin n_fail++; $display("FAIL rst_data got %h want 0", wm_data); end
    n_cmp++; if ({s_ready, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got %b want 000", {s_ready, busy, done}); end
    n_cmp++; if ({overflow_error, count_error} !== 2'b00) begin n_fail++; $display("FAIL rst_err got %b want 00", {overflow_error, count_error}); end
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    int base, n, expw;
    logic [BC-1:0] ew;
    for (int it = 0; it < 5; it++) begin
      base = (it == 0) ? 0 : int'($urandom_range(0, DEPTH - 1));
      n    = (it == 0) ? 8 : int'($urandom_range(1, 12));
      expw = n + int'($urandom_range(0, 1));
      drive_load(base, n, expw, 0, -1, -1);
      foreach (obs[i]) begin
        ew = exp_wen(base, obs[i].acc);
        n_cmp++;
        if (obs[i].wen !== ew) begin n_fail++; $display("FAIL b2b_wen it%0d cyc%0d got %b want %b", it, i, obs[i].wen, ew); end
        if (ew != '0) begin
          n_cmp++;
          if (obs[i].addr !== AW'(exp_row(base, obs[i].acc)) || obs[i].data !== beats[obs[i].acc]) begin
            n_fail++; $display("FAIL b2b_word it%0d beat%0d got %0d/%h want %0d/%h", it, obs[i].acc, obs[i].addr, obs[i].data, exp_row(base, obs[i].acc), beats[obs[i].acc]);
          end
        end
        n_cmp++;
        if ({obs[i].done, obs[i].busy, obs[i].rdy} !== {obs[i].mst == 2, obs[i].mst != 0, obs[i].mst == 1}) begin
          n_fail++; $display("FAIL b2b_ctl it%0d cyc%0d got %b want mst=%0d", it, i, {obs[i].done, obs[i].busy, obs[i].rdy}, obs[i].mst);
        end
      end
      n_cmp++;
      if ({obs[$].ovf, obs[$].cerr} !== {exp_ovf(base, n), exp_cerr(n, expw)}) begin
        n_fail++; $display("FAIL b2b_flags it%0d got %b want %b", it, {obs[$].ovf, obs[$].cerr}, {exp_ovf(base, n), exp_cerr(n, expw)});
      end
    end
  endtask

  task automatic test_gapped();
    logic [BC-1:0] ew;
    int nw;
    drive_load(37, 5, 5, 1, -1, -1);
    nw = 0;
    foreach (obs[i]) begin
      ew = exp_wen(37, obs[i].acc);
      if (obs[i].wen != '0) nw++;
      n_cmp++;
      if (obs[i].wen !== ew) begin n_fail++; $display("FAIL gap_wen cyc%0d got %b want %b", i, obs[i].wen, ew); end
      if (ew != '0) begin
        n_cmp++;
        if (obs[i].addr !== AW'(exp_row(37, obs[i].acc)) || obs[i].data !== beats[obs[i].acc]) begin
          n_fail++; $display("FAIL gap_word beat%0d got %0d/%h want %0d/%h", obs[i].acc, obs[i].addr, obs[i].data, exp_row(37, obs[i].acc), beats[obs[i].acc]);
        end
      end
      n_cmp++;
      if (obs[i].done !== (obs[i].mst == 2)) begin n_fail++; $display("FAIL gap_done cyc%0d got %b want %b", i, obs[i].done, obs[i].mst == 2); end
    end
    n_cmp++;
    if (nw != 5) begin n_fail++; $display("FAIL gap_nwrites got %0d want 5", nw); end
  endtask

  task automatic test_overflow();
    logic [BC-1:0] ew;
    drive_load(DEPTH - 1, 6, 6, 0, -1, -1);
    foreach (obs[i]) begin
      ew = exp_wen(DEPTH - 1, obs[i].acc);
      n_cmp++;
      if (obs[i].wen !== ew) begin n_fail++; $display("FAIL ovf_wen cyc%0d got %b want %b", i, obs[i].wen, ew); end
      if (ew != '0) begin
        n_cmp++;
        if (obs[i].addr !== AW'(DEPTH - 1) || obs[i].data !== beats[obs[i].acc]) begin
          n_fail++; $display("FAIL ovf_word beat%0d got %0d/%h want %0d/%h", obs[i].acc, obs[i].addr, obs[i].data, DEPTH - 1, beats[obs[i].acc]);
        end
      end
      n_cmp++;
      if (obs[i].done !== (obs[i].mst == 2)) begin n_fail++; $display("FAIL ovf_done cyc%0d got %b want %b", i, obs[i].done, obs[i].mst == 2); end
    end
    n_cmp++;
    if (obs[$].ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", obs[$].ovf); end
  endtask

  task automatic test_stray_start();
    logic [BC-1:0] ew;
    drive_load(20, 8, 8, 0, 2, -1);
    foreach (obs[i]) begin
      ew = exp_wen(20, obs[i].acc);
      n_cmp++;
      if (obs[i].wen !== ew) begin n_fail++; $display("FAIL stray_wen cyc%0d got %b want %b", i, obs[i].wen, ew); end
      if (ew != '0) begin
        n_cmp++;
        if (obs[i].addr !== AW'(exp_row(20, obs[i].acc)) || obs[i].data !== beats[obs[i].acc]) begin
          n_fail++; $display("FAIL stray_word beat%0d got %0d/%h want %0d/%h", obs[i].acc, obs[i].addr, obs[i].data, exp_row(20, obs[i].acc), beats[obs[i].acc]);
        end
      end
    end
    n_cmp++;
    if (obs[$].ovf !== 1'b0) begin n_fail++; $display("FAIL stray_ovf_cleared got %b want 0", obs[$].ovf); end
  endtask

  task automatic test_reset_mid_load();
    logic [BC-1:0] ew;
    drive_load(0, 8, 8, 0, -1, 3);
    foreach (obs[i]) begin
      ew = exp_wen(0, obs[i].acc);
      n_cmp++;
      if (obs[i].wen !== ew) begin n_fail++; $display("FAIL abort_wen cyc%0d got %b want %b", i, obs[i].wen, ew); end
      n_cmp++;
      if ({obs[i].done, obs[i].busy, obs[i].rdy} !== {obs[i].mst == 2, obs[i].mst != 0, obs[i].mst == 1}) begin
        n_fail++; $display("FAIL abort_ctl cyc%0d got %b want mst=%0d", i, {obs[i].done, obs[i].busy, obs[i].rdy}, obs[i].mst);
      end
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({wm_wen, busy, s_ready} !== '0) begin n_fail++; $display("FAIL abort_idle got %b want 0", {wm_wen, busy, s_ready}); end
    end
    drive_load(0, 4, 4, 0, -1, -1);
    foreach (obs[i]) begin
      ew = exp_wen(0, obs[i].acc);
      n_cmp++;
      if (obs[i].wen !== ew) begin n_fail++; $display("FAIL restart_wen cyc%0d got %b want %b", i, obs[i].wen, ew); end
      if (ew != '0) begin
        n_cmp++;
        if (obs[i].addr !== AW'(0) || obs[i].data !== beats[obs[i].acc]) begin
          n_fail++; $display("FAIL restart_word beat%0d got %0d/%h want 0/%h", obs[i].acc, obs[i].addr, obs[i].data, beats[obs[i].acc]);
        end
      end
    end
  endtask

  task automatic test_count_check();
    drive_load(5, 3, 4, 0, -1, -1);
    n_cmp++;
    if (obs[$].cerr !== exp_cerr(3, 4)) begin n_fail++; $display("FAIL cnt_short got %b want %b", obs[$].cerr, exp_cerr(3, 4)); end
    drive_load(5, 3, 3, 0, -1, -1);
    n_cmp++;
    if (obs[$].cerr !== exp_cerr(3, 3)) begin n_fail++; $display("FAIL cnt_exact got %b want %b", obs[$].cerr, exp_cerr(3, 3)); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_overflow();
    test_stray_start();
    test_reset_mid_load();
    test_count_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_memory_write_control.md
WEIGHT_MEMORY_WRITE_CONTROL -- requirements
Module: weight_memory_write_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one stream beat and one bank word.
REQ-002 SHALL have parameter BANK_COUNT, default 4, number of weight memory banks (power of two, >=2).
REQ-003 SHALL have parameter BANK_DEPTH, default 512, words per bank (power of two); AW = $clog2(BANK_DEPTH).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle load request.
REQ-007 SHALL have port base_addr  input  AW  first bank address of the load; sampled on accepted start.
REQ-008 SHALL have port expected_words  input  16  beat count of the load; sampled on accepted start.
REQ-009 SHALL have ports s_data/s_valid/s_last  input  DATA_WIDTH/1/1  weight stream from the external AXIS demux (TID 0).
REQ-010 SHALL have port s_ready  output  1  stream ready.
REQ-011 SHALL have ports wm_wen/wm_addr/wm_data  output  BANK_COUNT/AW/DATA_WIDTH  weight memory write port, one-hot wen.
REQ-012 SHALL have ports busy/done  output  1/1  load in progress / one-cycle completion pulse.
REQ-013 SHALL have ports overflow_error/count_error  output  1/1  sticky error flags.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-015 IDLE -> LOAD when start=1; samples base_addr, expected_words; clears word counter, bank pointer and both error flags.
REQ-016 start SHALL be ignored in LOAD and DONE.
REQ-017 s_ready SHALL be 1 exactly in LOAD; a beat is accepted when s_valid=1 and s_ready=1.
REQ-018 Beat k (k from 0) of a load SHALL go to bank k mod BANK_COUNT at address base_addr + floor(k/BANK_COUNT).
REQ-019 Write outputs SHALL be registered: wm_wen/wm_addr/wm_data valid the cycle after acceptance; wm_wen=0 in all other cycles.
REQ-020 Bank pointer SHALL rotate 0..BANK_COUNT-1; row address increments when pointer wraps from BANK_COUNT-1 to 0.
REQ-021 If row address would exceed BANK_DEPTH-1, the beat SHALL still be accepted, wm_wen SHALL stay 0, overflow_error SHALL set; address SHALL NOT wrap to 0.
REQ-022 Accepted beat with s_last=1 SHALL move LOAD -> DONE; DONE -> IDLE next cycle unconditionally.
REQ-023 done SHALL be 1 for exactly the DONE cycle, coincident with the last beat's write on wm_*.
REQ-024 busy SHALL be 1 in LOAD and DONE, 0 in IDLE.
REQ-025 Word counter SHALL be 16 bits, saturating at 0xFFFF.
REQ-026 Error flags SHALL hold until the next accepted start or reset.

Reset
REQ-027 resetn=0 at a clock edge SHALL force IDLE, counters/pointer to 0, s_ready=0, wm_wen=0, wm_addr=0, wm_data=0, busy=0, done=0, both error flags 0.
REQ-028 Reset mid-load SHALL abort immediately; no pending write SHALL be issued after reset.

Configuration
REQ-029 Macro WEIGHT_WORD_COUNT_CHECK_EN defined: at the last beat, count_error SHALL set if accepted beats (including last) != expected_words.
REQ-030 Macro not defined: count_error SHALL be tied 0 and expected_words ignored; all other behaviour unchanged.

Verification
REQ-031 base_addr=0, 8 beats D0..D7, last on D7 -> bank0 addr0=D0, bank1 addr0=D1, ..., bank3 addr1=D7; done one cycle after D7 accepted.
REQ-032 s_valid toggled every other cycle, 5 beats -> writes identical to back-to-back case, wm_wen only on accepted-beat+1 cycles.
REQ-033 base_addr=511, 6 beats -> beats 0-3 written at 511, beats 4-5 dropped, overflow_error=1, done pulses.
REQ-034 start pulsed during LOAD with base_addr=100 -> ignored; load continues at original addresses.
REQ-035 resetn=0 after 3rd beat of 8 -> no further wm_wen, state IDLE, s_ready=0; new start loads from bank0.
REQ-036 With WEIGHT_WORD_COUNT_CHECK_EN, expected_words=4, last on 3rd beat -> count_error=1; expected_words=3 -> count_error=0.
